imem_boot_loader: RTL and testbench

- Boot sequencer for the single-cycle RISC-V core.
- Accepts 32-bit instruction words over a valid/ready stream and writes each one little-endian, one byte per cycle, into the core's byte-wide instruction memory.
- Holds the core in reset while loading and releases it once loading completes.
- Replaces the testbench-side word-to-byte split and becomes the only writer of instruction memory.

---
 rtl/imem_boot_loader_if.sv | 30 +++
 rtl/imem_boot_loader.sv | 150 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Word-stream input and byte-wide instruction-memory write bus for the boot loader.
// The slave modport is the loader side; the master modport is the host/bench side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              word_valid;
  logic [31:0]       word_data;
  logic              word_last;
  logic              word_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              overflow_err;

  modport slave (
    input  start, word_valid, word_data, word_last,
    output word_ready, imem_we, imem_addr, imem_wdata,
           core_rst, busy, done, overflow_err
  );

  modport master (
    output start, word_valid, word_data, word_last,
    input  word_ready, imem_we, imem_addr, imem_wdata,
           core_rst, busy, done, overflow_err
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot sequencer: streams 32-bit words into byte-wide instruction memory
// (little-endian, one byte per cycle) and holds the core in reset until done.
module imem_boot_loader #(
  parameter int NUM_WORDS = 64,
  parameter int ADDR_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  imem_boot_loader_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  if ((longint'(1) << ADDR_W) < 4 * longint'(NUM_WORDS)) begin : g_addr_check
    $error("imem_boot_loader: ADDR_W too small for NUM_WORDS");
  end

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    RELEASE,
    RUN
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [1:0]        byte_idx_q;
  logic [31:0]       held_word_q;
  logic              held_last_q;

  logic              word_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [7:0]        imem_wdata_q;
  logic              core_rst_q;
  logic              busy_q;
  logic              done_q;
  logic              overflow_q;

  logic [CNT_W-1:0]  word_cnt_d;
  logic [1:0]        byte_idx_d;
  logic [ADDR_W-1:0] word_base;
  logic              at_capacity;

  always_comb begin
    word_cnt_d  = word_cnt_q + CNT_W'(1);
    byte_idx_d  = byte_idx_q + 2'd1;
    word_base   = ADDR_W'({word_cnt_q, 2'b00});
    at_capacity = (word_cnt_d == CNT_W'(NUM_WORDS));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      byte_idx_q   <= '0;
      held_word_q  <= '0;
      held_last_q  <= 1'b0;
      word_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q      <= ACCEPT;
            word_cnt_q   <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            word_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end

        ACCEPT: begin
          if (bus.word_valid) begin
            held_word_q  <= bus.word_data;
            held_last_q  <= bus.word_last;
            byte_idx_q   <= '0;
            word_ready_q <= 1'b0;
            imem_we_q    <= 1'b1;
            imem_addr_q  <= word_base;
            imem_wdata_q <= bus.word_data[7:0];
            state_q      <= WRITE;
          end
        end

        WRITE: begin
          if (byte_idx_q == 2'd3) begin
            word_cnt_q <= word_cnt_d;
            imem_we_q  <= 1'b0;
            if (held_last_q || at_capacity) begin
              if (!held_last_q) begin
                overflow_q <= 1'b1;
              end
              state_q <= RELEASE;
            end else begin
              word_ready_q <= 1'b1;
              state_q      <= ACCEPT;
            end
          end else begin
            // Incrementing the truncated address equals word_cnt*4+byte_idx mod 2^ADDR_W.
            byte_idx_q   <= byte_idx_d;
            imem_addr_q  <= imem_addr_q + ADDR_W'(1);
            imem_wdata_q <= held_word_q[{byte_idx_d, 3'b000} +: 8];
          end
        end

        RELEASE: begin
          state_q    <= RUN;
          core_rst_q <= 1'b1;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
        end

        RUN: begin
          if (bus.start) begin
            state_q      <= ACCEPT;
            core_rst_q   <= 1'b0;
            done_q       <= 1'b0;
            word_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            word_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.word_ready   = word_ready_q;
  assign bus.imem_we      = imem_we_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.imem_wdata   = imem_wdata_q;
  assign bus.core_rst     = core_rst_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a 64-word instance for most scenarios
// and a 4-word instance for the capacity-overflow case.
module tb_imem_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(8)) b ();
  imem_boot_loader_if #(.ADDR_W(8)) b4 ();

  imem_boot_loader #(.NUM_WORDS(64), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  imem_boot_loader #(.NUM_WORDS(4), .ADDR_W(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem  [256];
  logic [7:0] mem4 [256];
  int wr_cnt = 0, acc_cnt = 0, we_in_acc = 0;
  int wr4_cnt = 0, acc4_cnt = 0, wr4_hi = 0;

  // Memory models and event counters, sampled with pre-edge values.
  always @(posedge clk) begin
    if (b.imem_we) begin
      mem[b.imem_addr] = b.imem_wdata;
      wr_cnt++;
    end
    if (b.imem_we && b.word_ready) we_in_acc++;
    if (b.word_valid && b.word_ready) acc_cnt++;
    if (b4.imem_we) begin
      mem4[b4.imem_addr] = b4.imem_wdata;
      wr4_cnt++;
      if (b4.imem_addr >= 8'd16) wr4_hi++;
    end
    if (b4.word_valid && b4.word_ready) acc4_cnt++;
  end

  task automatic pulse_start();
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int unsigned n;
    n = 0;
    b.word_valid = 1'b1;
    b.word_data  = d;
    b.word_last  = last;
    while (!b.word_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_word_timeout: word_ready %b required 1 for word %h", b.word_ready, d);
    end
    @(negedge clk);
    b.word_valid = 1'b0;
  endtask

  task automatic send_word4(input logic [31:0] d);
    int unsigned n;
    n = 0;
    b4.word_valid = 1'b1;
    b4.word_data  = d;
    b4.word_last  = 1'b0;
    while (!b4.word_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b4.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_word4_timeout: word_ready %b required 1 for word %h", b4.word_ready, d);
    end
    @(negedge clk);
    b4.word_valid = 1'b0;
  endtask

  task automatic wait_wr(input logic [7:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (b.imem_we === 1'b1 && b.imem_addr === a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int base;
    base = wr_cnt;
    rst = 1'b0;
    b.word_valid  = 1'b1;
    b4.word_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({b.word_ready, b.imem_we, b.core_rst, b.busy, b.done, b.overflow_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000",
               {b.word_ready, b.imem_we, b.core_rst, b.busy, b.done, b.overflow_err});
    end
    checks++;
    if ({b.imem_addr, b.imem_wdata} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus: got %h required 0000", {b.imem_addr, b.imem_wdata});
    end
    checks++;
    if (wr_cnt - base !== 0) begin
      errors++;
      $display("FAIL reset_no_write: got %0d writes required 0", wr_cnt - base);
    end
    b.word_valid  = 1'b0;
    b4.word_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({b.word_ready, b.busy, b.core_rst} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required 000", {b.word_ready, b.busy, b.core_rst});
    end
  endtask

  task automatic test_normal_load();
    logic [7:0] exp_b [12];
    int base;
    bit ok;
    exp_b = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00,
              8'hB3, 8'h81, 8'h20, 8'h00};
    base = wr_cnt;
    pulse_start();
    checks++;
    if ({b.word_ready, b.busy, b.core_rst} !== 3'b110) begin
      errors++;
      $display("FAIL accept_state: got %b required 110", {b.word_ready, b.busy, b.core_rst});
    end
    send_word(32'h00500093, 1'b0);
    send_word(32'h00300113, 1'b0);
    send_word(32'h002081B3, 1'b1);
    wait_wr(8'd11, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL normal_addr11_seen: got 0 required 1");
    end
    @(negedge clk);
    checks++;
    if ({b.core_rst, b.busy, b.imem_we, b.done} !== 4'b0100) begin
      errors++;
      $display("FAIL release_cycle: got %b required 0100", {b.core_rst, b.busy, b.imem_we, b.done});
    end
    @(negedge clk);
    checks++;
    if ({b.core_rst, b.done, b.busy} !== 3'b110) begin
      errors++;
      $display("FAIL run_after_load: got %b required 110", {b.core_rst, b.done, b.busy});
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (mem[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL normal_byte[%0d]: got %h required %h", i, mem[i], exp_b[i]);
      end
    end
    checks++;
    if (wr_cnt - base !== 12) begin
      errors++;
      $display("FAIL normal_write_count: got %0d required 12", wr_cnt - base);
    end
    checks++;
    if (b.overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL normal_overflow: got %b required 0", b.overflow_err);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [4];
    int wbase, abase, ebase, idx, guard;
    bit ok;
    w = '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D, 32'h89ABCDEF};
    wbase = wr_cnt; abase = acc_cnt; ebase = we_in_acc;
    pulse_start();
    idx = 0; guard = 0;
    while (idx < 4 && guard < 500) begin
      if (b.word_ready && $urandom_range(0, 2) != 0) begin
        b.word_valid = 1'b1;
        b.word_data  = w[idx];
        b.word_last  = (idx == 3);
        idx++;
      end else begin
        b.word_valid = !b.word_ready && ($urandom_range(0, 1) == 1);
        b.word_data  = $urandom;
        b.word_last  = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      guard++;
    end
    b.word_valid = 1'b0;
    wait_wr(8'd15, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_addr15_seen: got 0 required 1");
    end
    repeat (2) @(negedge clk);
    checks++;
    if (acc_cnt - abase !== 4) begin
      errors++;
      $display("FAIL bp_accept_count: got %0d required 4", acc_cnt - abase);
    end
    checks++;
    if (we_in_acc - ebase !== 0) begin
      errors++;
      $display("FAIL bp_write_in_accept: got %0d required 0", we_in_acc - ebase);
    end
    checks++;
    if (wr_cnt - wbase !== 16) begin
      errors++;
      $display("FAIL bp_write_count: got %0d required 16", wr_cnt - wbase);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== w[i/4][8*(i%4) +: 8]) begin
        errors++;
        $display("FAIL bp_byte[%0d]: got %h required %h", i, mem[i], w[i/4][8*(i%4) +: 8]);
      end
    end
    checks++;
    if ({b.core_rst, b.done} !== 2'b11) begin
      errors++;
      $display("FAIL bp_run: got %b required 11", {b.core_rst, b.done});
    end
  endtask

  task automatic test_overflow();
    bit saw_ready;
    int wbase, abase, hbase;
    wbase = wr4_cnt; abase = acc4_cnt; hbase = wr4_hi;
    b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    for (int i = 0; i < 4; i++) send_word4(32'h03020100 + 32'h04040404 * i);
    b4.word_valid = 1'b1;
    b4.word_data  = 32'hFFFFFFFF;
    b4.word_last  = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (b4.word_ready) saw_ready = 1'b1;
    end
    b4.word_valid = 1'b0;
    checks++;
    if (saw_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_fifth_ready: got %b required 0", saw_ready);
    end
    checks++;
    if (acc4_cnt - abase !== 4) begin
      errors++;
      $display("FAIL ovf_accept_count: got %0d required 4", acc4_cnt - abase);
    end
    checks++;
    if (wr4_cnt - wbase !== 16) begin
      errors++;
      $display("FAIL ovf_write_count: got %0d required 16", wr4_cnt - wbase);
    end
    checks++;
    if (wr4_hi - hbase !== 0) begin
      errors++;
      $display("FAIL ovf_addr16_write: got %0d required 0", wr4_hi - hbase);
    end
    checks++;
    if ({b4.overflow_err, b4.done, b4.core_rst, b4.busy} !== 4'b1110) begin
      errors++;
      $display("FAIL ovf_flags: got %b required 1110",
               {b4.overflow_err, b4.done, b4.core_rst, b4.busy});
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem4[i] !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_byte[%0d]: got %h required %h", i, mem4[i], 8'(i));
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] exp_b [4];
    bit ok;
    exp_b = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
    pulse_start();
    send_word(32'hA5A5A5A5, 1'b0);
    send_word(32'h44332211, 1'b0);
    wait_wr(8'd6, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_addr6_seen: got 0 required 1");
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({b.word_ready, b.imem_we, b.core_rst, b.busy, b.done, b.overflow_err,
         b.imem_addr, b.imem_wdata} !== 22'b0) begin
      errors++;
      $display("FAIL mid_async_reset: got %h required 0",
               {b.word_ready, b.imem_we, b.core_rst, b.busy, b.done, b.overflow_err,
                b.imem_addr, b.imem_wdata});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({b.core_rst, b.word_ready, b.imem_we} !== 3'b000) begin
      errors++;
      $display("FAIL mid_idle_hold: got %b required 000", {b.core_rst, b.word_ready, b.imem_we});
    end
    pulse_start();
    send_word(32'h0BADF00D, 1'b1);
    wait_wr(8'd3, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_reload_addr3_seen: got 0 required 1");
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({b.core_rst, b.done, b.overflow_err} !== 3'b110) begin
      errors++;
      $display("FAIL mid_reload_run: got %b required 110", {b.core_rst, b.done, b.overflow_err});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL mid_byte[%0d]: got %h required %h", i, mem[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reload();
    logic [7:0] exp_b [8];
    int wbase, abase;
    bit ok;
    exp_b = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
    wbase = wr_cnt; abase = acc_cnt;
    pulse_start();
    checks++;
    if ({b.core_rst, b.done, b.busy} !== 3'b001) begin
      errors++;
      $display("FAIL reload_hold_core: got %b required 001", {b.core_rst, b.done, b.busy});
    end
    send_word(32'h76543210, 1'b0);
    pulse_start();
    send_word(32'hFEDCBA98, 1'b1);
    pulse_start();
    wait_wr(8'd7, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reload_addr7_seen: got 0 required 1");
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({b.core_rst, b.done} !== 2'b11) begin
      errors++;
      $display("FAIL reload_run: got %b required 11", {b.core_rst, b.done});
    end
    checks++;
    if (wr_cnt - wbase !== 8) begin
      errors++;
      $display("FAIL reload_write_count: got %0d required 8", wr_cnt - wbase);
    end
    checks++;
    if (acc_cnt - abase !== 2) begin
      errors++;
      $display("FAIL reload_accept_count: got %0d required 2", acc_cnt - abase);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL reload_byte[%0d]: got %h required %h", i, mem[i], exp_b[i]);
      end
    end
  endtask

  initial begin
    b.start = 1'b0;  b.word_valid = 1'b0;  b.word_data = '0;  b.word_last = 1'b0;
    b4.start = 1'b0; b4.word_valid = 1'b0; b4.word_data = '0; b4.word_last = 1'b0;
    @(negedge clk);
    test_reset();
    test_normal_load();
    test_backpressure();
    test_overflow();
    test_reset_midload();
    test_reload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
